fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main control decoder.
- Holds the PC and issues req/ack reads to instruction memory.
- Latches the returned word and presents `opcode`/`funct` fields to decode under a valid/ready handshake.
- Computes the next PC at retire as sequential or BEQ-taken.

---
 rtl/mips_pkg.sv | 17 +
 rtl/next_pc.sv | 22 ++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM state encoding and
// the instruction word width used by the fetch and decode stages.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  typedef enum logic {
    FETCH_S = 1'b0,
    HOLD_S  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC computation: sequential (pc + 4) or BEQ-taken
// (pc + 4 + offset*4). All arithmetic wraps modulo 2^ADDR_W.
module next_pc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_next
);

  logic [31:0] offset_bytes;

  // Word offset to byte offset; the two zero LSBs keep pc word aligned.
  always_comb begin
    offset_bytes = branch_offset << 2;
    pc_plus4     = pc + ADDR_W'(4);
    pc_next      = branch_taken ? (pc_plus4 + offset_bytes[ADDR_W-1:0]) : pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word over req/ack and
// presents it to decode under a valid/ready handshake until it retires.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  input  logic               branch_taken,
  input  logic [31:0]        branch_offset,
  output logic [31:0]        retired_count
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              retire;

  next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_plus4      (pc_plus4),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_S;
    else       state <= state_next;
  end

  // Request is held until ack; instr_valid is simply "in HOLD".
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH_S: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = HOLD_S;
      end
      HOLD_S: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          retire     = 1'b1;
          state_next = FETCH_S;
        end
      end
      default: state_next = FETCH_S;
    endcase
  end

  // Acks outside FETCH are dropped; reset discards coincident data or retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      instr         <= '0;
      retired_count <= '0;
    end else begin
      if (state == FETCH_S && imem_ack) instr <= imem_rdata;
      if (retire) begin
        pc            <= pc_next;
        retired_count <= retired_count + 32'd1;
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses
// and retired instructions, monitors pop and compare as the DUT presents them.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] retired_count;

  logic        wrap_reset;
  logic        wrap_req;
  logic [31:0] wrap_addr;
  logic        wrap_valid;
  logic [31:0] wrap_instr;
  logic [5:0]  wrap_opcode;
  logic [5:0]  wrap_funct;
  logic [31:0] wrap_pc;
  logic [31:0] wrap_pc_plus4;
  logic [31:0] wrap_retired;

  int check_count = 0;
  int pass_count  = 0;
  int cyc         = 0;
  int ack_delay   = 0;
  int wait_cnt    = 0;

  logic [31:0] exp_fetch_q[$];
  ret_t        exp_ret_q[$];

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .funct         (funct),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .retired_count (retired_count)
  );

  // Free-running zero-wait instance used to exercise PC wrap-around.
  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .reset         (wrap_reset),
    .imem_req      (wrap_req),
    .imem_addr     (wrap_addr),
    .imem_ack      (wrap_req),
    .imem_rdata    (32'h0043_2020),
    .instr_valid   (wrap_valid),
    .instr_ready   (1'b1),
    .instr         (wrap_instr),
    .opcode        (wrap_opcode),
    .funct         (wrap_funct),
    .pc            (wrap_pc),
    .pc_plus4      (wrap_pc_plus4),
    .branch_taken  (1'b0),
    .branch_offset (32'h0),
    .retired_count (wrap_retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return {OP_LW,    26'h022_0004};
      32'd4:   return {OP_RTYPE, 26'h043_2020};
      32'd8:   return {OP_BEQ,   26'h022_FFFE};
      32'd12:  return {OP_SW,    26'h022_0008};
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Queue the expected fetch address, then wait (bounded) for instr_valid.
  task automatic fetchWait(input logic [31:0] exp_pc, input int ack_dly);
    int n = 0;
    exp_fetch_q.push_back(exp_pc);
    ack_delay = ack_dly;
    while (instr_valid !== 1'b1 && n < 20) begin
      checkOutput("fetch_req_high", 32'(imem_req), 32'd1);
      checkOutput("fetch_addr_stable", imem_addr, exp_pc);
      step();
      n++;
    end
    if (n >= 20) begin
      check_count++;
      $display("[TB] FAIL fetch_timeout: instr_valid %b required 1 for pc %h", instr_valid, exp_pc);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] exp_pc, input int ack_dly, input int ready_dly,
                               input logic taken, input logic [31:0] offset);
    exp_ret_q.push_back(ret_t'{pc: exp_pc, word: mem_word(exp_pc)});
    fetchWait(exp_pc, ack_dly);
    branch_taken  = taken;
    branch_offset = offset;
    instr_ready   = 1'b0;
    for (int i = 0; i < ready_dly; i++) begin
      step();
      checkOutput("hold_valid", 32'(instr_valid), 32'd1);
      checkOutput("hold_pc", pc, exp_pc);
      checkOutput("hold_instr", instr, mem_word(exp_pc));
    end
    instr_ready = 1'b1;
    step();
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
  endtask

  // Instruction memory model: acks after ack_delay cycles of a held request.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #3;
      if (imem_req !== 1'b1) begin
        wait_cnt = 0;
        imem_ack = 1'b0;
      end else if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        wait_cnt++;
        imem_ack = 1'b0;
      end
      if (reset) wait_cnt = 0;
    end
  end

  // Fetch monitor: every accepted request must match the next expected address.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && imem_req && imem_ack) begin
        if (exp_fetch_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_fetch: addr %h with no expected fetch", imem_addr);
        end else begin
          checkOutput("fetch_addr", imem_addr, exp_fetch_q.pop_front());
        end
      end
    end
  end

  // Retire monitor: compares the presented instruction and derived fields.
  initial begin : retire_mon
    ret_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && instr_valid && instr_ready) begin
        if (exp_ret_q.size() == 0) begin
          check_count++;
          $display("[TB] FAIL unexpected_retire: pc %h with no expected retire", pc);
        end else begin
          e = exp_ret_q.pop_front();
          checkOutput("retire_pc", pc, e.pc);
          checkOutput("retire_instr", instr, e.word);
          checkOutput("retire_opcode", 32'(opcode), 32'(e.word[31:26]));
          checkOutput("retire_funct", 32'(funct), 32'(e.word[5:0]));
          checkOutput("retire_pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  // Wrap instance: reset at 0xFFFFFFFC, one sequential retire lands on 0.
  initial begin
    wrap_reset = 1'b1;
    repeat (2) step();
    checkOutput("wrap_reset_pc", wrap_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_reset_req", 32'(wrap_req), 32'd1);
    wrap_reset = 1'b0;
    step();
    checkOutput("wrap_valid", 32'(wrap_valid), 32'd1);
    checkOutput("wrap_pc_plus4", wrap_pc_plus4, 32'h0000_0000);
    checkOutput("wrap_instr", wrap_instr, 32'h0043_2020);
    checkOutput("wrap_opcode", 32'(wrap_opcode), 32'(OP_RTYPE));
    checkOutput("wrap_funct", 32'(wrap_funct), 32'h20);
    step();
    checkOutput("wrap_next_addr", wrap_addr, 32'h0000_0000);
    checkOutput("wrap_next_req", 32'(wrap_req), 32'd1);
    checkOutput("wrap_retired", wrap_retired, 32'd1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc0;
    reset         = 1'b1;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
    repeat (2) step();
    checkOutput("reset_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_retired", retired_count, 32'd0);
    checkOutput("reset_req", 32'(imem_req), 32'd1);

    $display("[TB] sequential run with zero-wait memory, BEQ taken at pc 8");
    cyc0  = cyc;
    reset = 1'b0;
    applyStimulus(32'd0, 0, 0, 1'b0, 32'h0);
    applyStimulus(32'd4, 0, 0, 1'b0, 32'h0);
    applyStimulus(32'd8, 0, 0, 1'b1, 32'hFFFF_FFFE);
    checkOutput("seq_retired", retired_count, 32'd3);
    checkOutput("seq_cycles", 32'(cyc - cyc0), 32'd6);

    $display("[TB] branch back to 4, BEQ not taken, delayed ack with backpressure");
    applyStimulus(32'd4, 0, 0, 1'b0, 32'h0);
    applyStimulus(32'd8, 0, 0, 1'b0, 32'hFFFF_FFFE);
    applyStimulus(32'd12, 3, 2, 1'b0, 32'h0);
    checkOutput("stall_retired", retired_count, 32'd6);

    $display("[TB] reset coincident with ack, then with retire");
    ack_delay = 0;
    reset     = 1'b1;
    step();
    checkOutput("rst_ack_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_ack_instr", instr, 32'h0);
    checkOutput("rst_ack_pc", pc, 32'h0);
    checkOutput("rst_ack_retired", retired_count, 32'd0);
    reset = 1'b0;
    fetchWait(32'd0, 0);
    instr_ready = 1'b1;
    reset       = 1'b1;
    step();
    checkOutput("rst_ret_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_ret_pc", pc, 32'h0);
    checkOutput("rst_ret_retired", retired_count, 32'd0);
    checkOutput("rst_ret_instr", instr, 32'h0);
    instr_ready = 1'b0;
    reset       = 1'b0;
    applyStimulus(32'd0, 0, 0, 1'b0, 32'h0);
    checkOutput("post_rst_retired", retired_count, 32'd1);

    reset = 1'b1;
    repeat (2) step();
    checkOutput("fetch_queue_empty", 32'(exp_fetch_q.size()), 32'd0);
    checkOutput("retire_queue_empty", 32'(exp_ret_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
